bcd_subtractor_serial: RTL and testbench
========================================

BCD_SUBTRACTOR_SERIAL -- requirements
Module: bcd_subtractor_serial

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits per operand.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 A  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 B  input  4*DIGITS  subtrahend, packed BCD, same packing.
REQ-007 busy  output  1  high from the cycle after accepted start until the cycle before done.
REQ-008 done  output  1  one-cycle pulse; Diff, Neg and Err are valid while done is high and hold until the next accepted start.
REQ-009 Diff  output  4*DIGITS  magnitude |A-B|, packed BCD.
REQ-010 Neg  output  1  1 when A<B.
REQ-011 Err  output  1  1 when any A or B digit exceeded 9 at start.

Function
REQ-012 The block SHALL use states IDLE, SUB, NEG and DONE.
REQ-013 In IDLE with start=1, A and B SHALL be registered, the digit index cleared and carry set to 1; next state SUB, or DONE if any digit >9.
REQ-014 In SUB, one digit per cycle, LSD first: t = A_d + (9 - B_d) + carry (5-bit); if t>9 then digit = (t+6)[3:0], carry=1, else digit = t[3:0], carry=0.
REQ-015 After digit DIGITS-1 in SUB: carry=1 -> DONE with Neg=0; carry=0 -> NEG with index cleared and carry set to 1.
REQ-016 In NEG, one digit per cycle, R_d := (9 - R_d) + carry with the same >9 correction (ten's complement of the partial result); after digit DIGITS-1 -> DONE with Neg=1.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency from start cycle to done: DIGITS+1 cycles for A>=B, 2*DIGITS+1 for A<B, 1 cycle for an invalid digit.
REQ-019 Invalid digit: Diff=0, Neg=0, Err=1; no arithmetic performed.
REQ-020 A=B SHALL yield Diff=0, Neg=0 (never negative zero).
REQ-021 start while not in IDLE SHALL be ignored; A and B changes during busy SHALL NOT affect the result.
REQ-022 start in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted (back-to-back throughput = latency+1).
REQ-023 Err SHALL be cleared at each accepted start.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, Diff=0, Neg=0, Err=0, index=0, carry=0 on the next edge, from any state.
REQ-025 Reset mid-operation SHALL abort without asserting done; start in the cycle rst deasserts SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state enum, BCD_MAX=9 and BCD_CORR=6.
REQ-027 The per-digit add-with-correction (4-bit a, 4-bit b, cin -> 4-bit digit, cout) SHALL be one combinational sub-module bcd_digit_add, reused by SUB and NEG.
REQ-028 The digit index counter SHALL be sized clog2(DIGITS), with no wrap beyond DIGITS-1.

Verification
REQ-029 A=0042, B=0017, start at cycle 0 -> done at cycle 5, Diff=0025, Neg=0, Err=0.
REQ-030 A=0017, B=0042 -> done at cycle 9, Diff=0025, Neg=1.
REQ-031 Borrow chain: A=1000, B=0001 -> Diff=0999, Neg=0; A=0000, B=9999 -> Diff=9999, Neg=1.
REQ-032 A=5555, B=5555 -> Diff=0000, Neg=0; A=00A1, B=0000 -> done at cycle 1, Err=1, Diff=0000.
REQ-033 Start pulsed again at cycle 2 with new operands -> ignored, and the first result is unchanged; rst at cycle 3 -> no done, all outputs 0, and the next start runs normally.
REQ-034 Random valid operands, 1000 runs, checked against a decimal model for Diff, Neg and latency.

Source files
------------

// File: rtl/bcd_subtractor_serial_pkg.sv
// Purpose: shared types and BCD constants for the serial BCD subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_subtractor_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Purpose: one BCD digit add with decimal correction (a + b + cin).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a, b  : BCD digits (0..9)
//   cin   : carry in
//   digit : corrected BCD sum digit
//   cout  : decimal carry out
module bcd_digit_add
    import bcd_subtractor_serial_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] w_t;

    always_comb begin
        w_t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (w_t > {1'b0, BCD_MAX}) begin
            // Adding 6 skips the six unused codes; the bit-4 overflow is the decimal carry.
            digit = w_t[3:0] + BCD_CORR;
            cout  = 1'b1;
        end else begin
            digit = w_t[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Purpose: digit-serial packed-BCD subtractor producing |A-B| and a sign flag.
// Latency: DIGITS+1 cycles (A>=B), 2*DIGITS+1 (A<B), 1 cycle on an invalid digit.
// Backpressure: none; start is only honoured in IDLE, otherwise dropped.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request; operands A/B captured on the accepting edge
//   A, B          : packed BCD operands, digit 0 in bits [3:0]
//   busy          : high while digits are being processed
//   done          : one-cycle pulse; Diff/Neg/Err valid and held afterwards
//   Diff, Neg, Err: magnitude, A<B flag, invalid-digit flag
module bcd_subtractor_serial
    import bcd_subtractor_serial_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Diff,
    output logic                  Neg,
    output logic                  Err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t              r_state;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_res;
    logic [4*DIGITS-1:0] r_diff;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_busy;
    logic                r_done;
    logic                r_neg;
    logic                r_err;

    logic                w_invalid;
    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [3:0]          w_r_dig;
    logic [3:0]          w_add_a;
    logic [3:0]          w_add_b;
    logic [3:0]          w_sum;
    logic                w_cout;
    logic [4*DIGITS-1:0] w_res_next;

    // Any operand digit above 9 flags the request as invalid.
    always_comb begin
        w_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (A[i*4 +: 4] > BCD_MAX || B[i*4 +: 4] > BCD_MAX) begin
                w_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        w_a_dig = r_a[{r_idx, 2'b00} +: 4];
        w_b_dig = r_b[{r_idx, 2'b00} +: 4];
        w_r_dig = r_res[{r_idx, 2'b00} +: 4];
    end

    // SUB computes A + nines'(B) + carry; NEG computes 0 + nines'(R) + carry,
    // i.e. the ten's complement of the partial result, through the same adder.
    always_comb begin
        if (r_state == ST_SUB) begin
            w_add_a = w_a_dig;
            w_add_b = BCD_MAX - w_b_dig;
        end else begin
            w_add_a = 4'd0;
            w_add_b = BCD_MAX - w_r_dig;
        end
    end

    bcd_digit_add u_digit_add (
        .a     (w_add_a),
        .b     (w_add_b),
        .cin   (r_carry),
        .digit (w_sum),
        .cout  (w_cout)
    );

    // Partial result with the current digit already substituted, so the final
    // digit lands in Diff on the same edge the FSM moves to DONE.
    always_comb begin
        w_res_next = r_res;
        w_res_next[{r_idx, 2'b00} +: 4] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_res   <= '0;
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                        r_err   <= w_invalid;
                        if (w_invalid) begin
                            r_diff  <= '0;
                            r_neg   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        if (w_cout) begin
                            // Carry out means no borrow: A >= B, result is final.
                            r_diff  <= w_res_next;
                            r_neg   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= '0;
                            r_carry <= 1'b1;
                            r_state <= ST_NEG;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_NEG: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_diff  <= w_res_next;
                        r_neg   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Diff = r_diff;
    assign Neg  = r_neg;
    assign Err  = r_err;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Purpose: directed and random checks of bcd_subtractor_serial (DIGITS=4).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_bcd_subtractor_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Neg;
    logic        Err;

    int errs   = 0;
    int checks = 0;

    bcd_subtractor_serial #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Neg   (Neg),
        .Err   (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start in cycle 0 (driven at negedge), then count cycles to done.
    // Returns at the negedge of the done cycle; lat = 40 means timeout.
    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int busy_cnt);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input int exp_lat, input logic [15:0] exp_diff,
                            input logic exp_neg, input logic exp_err);
        int lat;
        int bc;
        run(a, b, lat, bc);
        check_eq({tag, ".lat"},  lat, exp_lat);
        check_eq({tag, ".diff"}, Diff, exp_diff);
        check_eq({tag, ".neg"},  Neg, exp_neg);
        check_eq({tag, ".err"},  Err, exp_err);
        check_eq({tag, ".busy_cycles"}, bc, exp_err ? 0 : exp_lat - 1);
    endtask

    initial begin
        int lat;
        int bc;
        int seen;
        int av;
        int bv;

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.diff", Diff, 0);
        check_eq("rst.neg",  Neg, 0);
        check_eq("rst.err",  Err, 0);

        directed("d42m17", 16'h0042, 16'h0017, 5, 16'h0025, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("pulse.done_low", done, 0);
        check_eq("hold.diff", Diff, 16'h0025);
        directed("d17m42", 16'h0017, 16'h0042, 9, 16'h0025, 1'b1, 1'b0);
        directed("d1000m1", 16'h1000, 16'h0001, 5, 16'h0999, 1'b0, 1'b0);
        directed("d0m9999", 16'h0000, 16'h9999, 9, 16'h9999, 1'b1, 1'b0);
        directed("deq", 16'h5555, 16'h5555, 5, 16'h0000, 1'b0, 1'b0);
        directed("dinvA", 16'h00A1, 16'h0000, 1, 16'h0000, 1'b0, 1'b1);
        directed("dinvB", 16'h0003, 16'hF000, 1, 16'h0000, 1'b0, 1'b1);
        directed("errclr", 16'h0009, 16'h0003, 5, 16'h0006, 1'b0, 1'b0);

        // Second start at cycle 2 with new operands, and operand churn while busy.
        @(negedge clk);
        A = 16'h0042; B = 16'h0017; start = 1'b1;          // cycle 0
        @(negedge clk); start = 1'b0;                       // cycle 1
        @(negedge clk); start = 1'b1; A = 16'h0001; B = 16'h0009;   // cycle 2
        @(negedge clk); start = 1'b0; A = 16'h9999; B = 16'h0000;   // cycle 3
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("ign.lat",  lat, 5);
        check_eq("ign.diff", Diff, 16'h0025);
        check_eq("ign.neg",  Neg, 0);
        @(negedge clk);
        check_eq("ign.no_restart", busy, 0);

        // Start in the DONE cycle is dropped; held into the IDLE cycle it is taken.
        run(16'h0042, 16'h0017, lat, bc);
        check_eq("b2b.first_lat", lat, 5);
        A = 16'h0100; B = 16'h0001; start = 1'b1;          // DONE cycle
        @(negedge clk);                                     // IDLE cycle
        check_eq("b2b.done_ignored", busy, 0);
        @(negedge clk); start = 1'b0;
        check_eq("b2b.accepted", busy, 1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b.lat",  lat, 5);
        check_eq("b2b.diff", Diff, 16'h0099);

        // Reset at cycle 3 aborts; start during reset is ignored.
        @(negedge clk);
        A = 16'h0017; B = 16'h0042; start = 1'b1;          // cycle 0
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; start = 1'b1;           // cycle 3
        @(negedge clk); rst = 1'b0; start = 1'b0;
        check_eq("abort.busy", busy, 0);
        check_eq("abort.diff", Diff, 0);
        check_eq("abort.neg",  Neg, 0);
        check_eq("abort.err",  Err, 0);
        seen = 0;
        repeat (12) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        check_eq("abort.no_done", seen, 0);
        directed("after_rst", 16'h0017, 16'h0042, 9, 16'h0025, 1'b1, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            av = $urandom_range(0, 9999);
            bv = (n % 10 == 0) ? av : $urandom_range(0, 9999);
            run(to_bcd(av), to_bcd(bv), lat, bc);
            check_eq("rnd.diff", Diff, to_bcd(av >= bv ? av - bv : bv - av));
            check_eq("rnd.neg",  Neg, (av < bv) ? 1 : 0);
            check_eq("rnd.lat",  lat, (av >= bv) ? 5 : 9);
            check_eq("rnd.err",  Err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
